// File: rtl/mips_ex_wb_core.sv
// Execute/writeback core: decoder, 32x32 register file, ALU with HI/LO, GPIO port.
// Optional feature macro: HILO_MULT_EN (mult/multu/mfhi/mflo and the HI/LO registers).
module mips_ex_wb_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_ex,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        alu_zero
);

    typedef enum logic [3:0] {
        ALU_AND   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_NOR   = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_ADD   = 4'd4,
        ALU_SUB   = 4'd5,
        ALU_MULT  = 4'd6,
        ALU_MULTU = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_SLT   = 4'd12,
        ALU_SLTU  = 4'd13
    } alu_op_t;

    typedef enum logic [2:0] {
        RES_ALU,
        RES_HI,
        RES_LO,
        RES_GPIO,
        RES_LUI
    } res_sel_t;

    typedef enum logic [1:0] {
        B_RT,
        B_SEXT,
        B_ZEXT
    } b_sel_t;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = instr_ex[31:26];
    assign rs    = instr_ex[25:21];
    assign rt    = instr_ex[20:16];
    assign rd    = instr_ex[15:11];
    assign shamt = instr_ex[10:6];
    assign funct = instr_ex[5:0];
    assign imm   = instr_ex[15:0];

    alu_op_t  alu_op;
    b_sel_t   b_sel;
    res_sel_t res_sel;
    logic     regwrite;
    logic     dst_rt;
    logic     gpio_we;
`ifdef HILO_MULT_EN
    logic     hilo_we;
`endif

    always_comb begin
        alu_op   = ALU_ADD;
        b_sel    = B_RT;
        res_sel  = RES_ALU;
        regwrite = 1'b0;
        dst_rt   = 1'b0;
        gpio_we  = 1'b0;
`ifdef HILO_MULT_EN
        hilo_we  = 1'b0;
`endif
        case (op)
            6'h00: begin
                regwrite = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu_op = ALU_ADD;
                    6'h22, 6'h23: alu_op = ALU_SUB;
                    6'h24:        alu_op = ALU_AND;
                    6'h25:        alu_op = ALU_OR;
                    6'h26:        alu_op = ALU_XOR;
                    6'h27:        alu_op = ALU_NOR;
                    6'h2A:        alu_op = ALU_SLT;
                    6'h2B:        alu_op = ALU_SLTU;
                    6'h00:        alu_op = ALU_SLL;
                    6'h02:        alu_op = ALU_SRL;
                    6'h03:        alu_op = ALU_SRA;
`ifdef HILO_MULT_EN
                    6'h18: begin
                        alu_op   = ALU_MULT;
                        regwrite = 1'b0;
                        hilo_we  = 1'b1;
                    end
                    6'h19: begin
                        alu_op   = ALU_MULTU;
                        regwrite = 1'b0;
                        hilo_we  = 1'b1;
                    end
                    6'h10:        res_sel = RES_HI;
                    6'h12:        res_sel = RES_LO;
`endif
                    default:      regwrite = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                alu_op = ALU_ADD;  b_sel = B_SEXT; regwrite = 1'b1; dst_rt = 1'b1;
            end
            6'h0A: begin
                alu_op = ALU_SLT;  b_sel = B_SEXT; regwrite = 1'b1; dst_rt = 1'b1;
            end
            6'h0B: begin
                alu_op = ALU_SLTU; b_sel = B_SEXT; regwrite = 1'b1; dst_rt = 1'b1;
            end
            6'h0C: begin
                alu_op = ALU_AND;  b_sel = B_ZEXT; regwrite = 1'b1; dst_rt = 1'b1;
            end
            6'h0D: begin
                alu_op = ALU_OR;   b_sel = B_ZEXT; regwrite = 1'b1; dst_rt = 1'b1;
            end
            6'h0E: begin
                alu_op = ALU_XOR;  b_sel = B_ZEXT; regwrite = 1'b1; dst_rt = 1'b1;
            end
            6'h0F: begin
                res_sel = RES_LUI; regwrite = 1'b1; dst_rt = 1'b1;
            end
            6'h23: begin
                res_sel = RES_GPIO; regwrite = 1'b1; dst_rt = 1'b1;
            end
            6'h2B:   gpio_we = 1'b1;
            default: ;
        endcase
    end

    // Register file; the write port is driven by the writeback stage.
    logic [31:0] regs [32];
    logic        wb_regwrite;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_regwrite && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_data = regs[rs];
        if (rs == 5'd0)
            rs_data = '0;
        else if (wb_regwrite && wb_addr == rs)
            rs_data = wb_data;
    end

    always_comb begin
        rt_data = regs[rt];
        if (rt == 5'd0)
            rt_data = '0;
        else if (wb_regwrite && wb_addr == rt)
            rt_data = wb_data;
    end

    // ALU
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_lo;
`ifdef HILO_MULT_EN
    logic [31:0] alu_hi;
    logic [63:0] prod;
`endif

    assign alu_a = rs_data;

    always_comb begin
        case (b_sel)
            B_SEXT:  alu_b = {{16{imm[15]}}, imm};
            B_ZEXT:  alu_b = {16'h0000, imm};
            default: alu_b = rt_data;
        endcase
    end

    always_comb begin
        alu_lo = '0;
`ifdef HILO_MULT_EN
        alu_hi = '0;
        prod   = '0;
`endif
        case (alu_op)
            ALU_AND:  alu_lo = alu_a & alu_b;
            ALU_OR:   alu_lo = alu_a | alu_b;
            ALU_NOR:  alu_lo = ~(alu_a | alu_b);
            ALU_XOR:  alu_lo = alu_a ^ alu_b;
            ALU_ADD:  alu_lo = alu_a + alu_b;
            ALU_SUB:  alu_lo = alu_a - alu_b;
`ifdef HILO_MULT_EN
            ALU_MULT: begin
                prod   = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
                alu_hi = prod[63:32];
                alu_lo = prod[31:0];
            end
            ALU_MULTU: begin
                prod   = {32'h0, alu_a} * {32'h0, alu_b};
                alu_hi = prod[63:32];
                alu_lo = prod[31:0];
            end
`else
            ALU_MULT, ALU_MULTU: alu_lo = '0;
`endif
            ALU_SLL:  alu_lo = alu_b << shamt;
            ALU_SRL:  alu_lo = alu_b >> shamt;
            ALU_SRA:  alu_lo = $signed(alu_b) >>> shamt;
            ALU_SLT:  alu_lo = {31'h0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_lo = {31'h0, alu_a < alu_b};
            default:  alu_lo = '0;
        endcase
    end

    assign alu_zero = (alu_lo == 32'h0);

`ifdef HILO_MULT_EN
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_we) begin
            hi_q <= alu_hi;
            lo_q <= alu_lo;
        end
    end
`endif

    logic [31:0] result;

    always_comb begin
        case (res_sel)
`ifdef HILO_MULT_EN
            RES_HI:   result = hi_q;
            RES_LO:   result = lo_q;
`endif
            RES_GPIO: result = gpio_in;
            RES_LUI:  result = {imm, 16'h0000};
            default:  result = alu_lo;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_regwrite <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
        end else begin
            wb_regwrite <= regwrite;
            wb_addr     <= dst_rt ? rt : rd;
            wb_data     <= result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            gpio_out <= '0;
        else if (gpio_we)
            gpio_out <= rt_data;
    end

endmodule

// File: tb/tb_mips_ex_wb_core.sv
// Directed bench for mips_ex_wb_core; register contents are observed through GPIO writes.
module tb_mips_ex_wb_core;

    logic        clk;
    logic        rst;
    logic [31:0] instr_ex;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;

    mips_ex_wb_core dut (
        .clk      (clk),
        .rst      (rst),
        .instr_ex (instr_ex),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .alu_zero (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HILO_MULT_EN
    localparam logic [31:0] EXP_MULT_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_MULT_LO  = 32'hFFFF_FFFE;
    localparam logic [31:0] EXP_MULTU_HI = 32'h0000_0001;
`else
    localparam logic [31:0] EXP_MULT_HI  = 32'h0;
    localparam logic [31:0] EXP_MULT_LO  = 32'h0;
    localparam logic [31:0] EXP_MULTU_HI = 32'h0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d,
                                         input logic [4:0] sh);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    task automatic step(input logic [31:0] ins);
        instr_ex = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic step_z(input logic [31:0] ins, input logic exp_z, input string tag);
        instr_ex = ins;
        #1;
        check(tag, {31'h0, alu_zero}, {31'h0, exp_z});
        @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [4:0] r, input logic [31:0] exp, input string tag);
        step(i_op(6'h2B, 5'd0, r, 16'h0));
        check(tag, gpio_out, exp);
    endtask

    initial begin
        rst      = 1'b1;
        instr_ex = '0;
        gpio_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_gpio", gpio_out, 32'h0);
        rst = 1'b0;
        show(5'd1, 32'h0, "reset_r1");

        // back-to-back dependence through the bypass
        step(i_op(6'h09, 5'd0, 5'd1, 16'h7FFF));
        step_z(i_op(6'h08, 5'd1, 5'd2, 16'hFFFF), 1'b0, "addi_zero");
        show(5'd2, 32'h0000_7FFE, "addi_r2");
        show(5'd1, 32'h0000_7FFF, "addiu_r1");

        step(i_op(6'h0F, 5'd0, 5'd3, 16'hDEAD));
        step(i_op(6'h0D, 5'd3, 5'd3, 16'hBEEF));
        step(r_op(6'h03, 5'd0, 5'd3, 5'd4, 5'd4));
        show(5'd3, 32'hDEAD_BEEF, "lui_ori_r3");
        show(5'd4, 32'hFDEA_DBEE, "sra_r4");
        step(r_op(6'h02, 5'd0, 5'd3, 5'd4, 5'd4));
        show(5'd4, 32'h0DEA_DBEE, "srl_r4");
        step(r_op(6'h00, 5'd0, 5'd3, 5'd4, 5'd4));
        show(5'd4, 32'hEADB_EEF0, "sll_r4");
        step(i_op(6'h0C, 5'd3, 5'd17, 16'hFFFF));
        show(5'd17, 32'h0000_BEEF, "andi_r17");
        step(i_op(6'h0E, 5'd3, 5'd18, 16'hFFFF));
        show(5'd18, 32'hDEAD_4110, "xori_r18");

        step(i_op(6'h09, 5'd0, 5'd5, 16'hFFFF));
        step(i_op(6'h09, 5'd0, 5'd6, 16'h0002));
        step(r_op(6'h18, 5'd5, 5'd6, 5'd0, 5'd0));
        step(r_op(6'h10, 5'd0, 5'd0, 5'd7, 5'd0));
        step(r_op(6'h12, 5'd0, 5'd0, 5'd8, 5'd0));
        show(5'd7, EXP_MULT_HI, "mult_hi");
        show(5'd8, EXP_MULT_LO, "mult_lo");
        step(r_op(6'h19, 5'd5, 5'd6, 5'd0, 5'd0));
        step(r_op(6'h10, 5'd0, 5'd0, 5'd7, 5'd0));
        show(5'd7, EXP_MULTU_HI, "multu_hi");

        gpio_in = 32'h1234_5678;
        step(i_op(6'h23, 5'd3, 5'd9, 16'h1234));
        instr_ex = i_op(6'h2B, 5'd0, 5'd9, 16'h0);
        #1;
        check("gpio_before_edge", gpio_out, EXP_MULTU_HI);
        @(posedge clk);
        #1;
        check("gpio_after_edge", gpio_out, 32'h1234_5678);

        step(i_op(6'h09, 5'd0, 5'd0, 16'h0005));
        show(5'd0, 32'h0, "r0_bypass");
        step_z(r_op(6'h21, 5'd0, 5'd0, 5'd10, 5'd0), 1'b1, "addu_zero");
        show(5'd10, 32'h0, "addu_r10");

        step(i_op(6'h0F, 5'd0, 5'd11, 16'h8000));
        step(i_op(6'h09, 5'd0, 5'd12, 16'h0001));
        step(r_op(6'h2A, 5'd11, 5'd12, 5'd13, 5'd0));
        step(r_op(6'h2B, 5'd11, 5'd12, 5'd14, 5'd0));
        show(5'd13, 32'h1, "slt_r13");
        show(5'd14, 32'h0, "sltu_r14");
        step(r_op(6'h23, 5'd12, 5'd11, 5'd15, 5'd0));
        show(5'd15, 32'h8000_0001, "subu_r15");
        step(r_op(6'h27, 5'd0, 5'd0, 5'd16, 5'd0));
        show(5'd16, 32'hFFFF_FFFF, "nor_r16");
        step(r_op(6'h3F, 5'd11, 5'd11, 5'd12, 5'd0));
        show(5'd12, 32'h1, "undef_nop");

        // reset with a pending $1 write and a pending GPIO write
        step(i_op(6'h09, 5'd0, 5'd1, 16'h0055));
        instr_ex = i_op(6'h2B, 5'd0, 5'd9, 16'h0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_gpio", gpio_out, 32'h0);
        instr_ex = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        show(5'd1, 32'h0, "rst_no_stale_r1");
        show(5'd9, 32'h0, "rst_r9");
        show(5'd3, 32'h0, "rst_r3");
        step(r_op(6'h10, 5'd0, 5'd0, 5'd7, 5'd0));
        show(5'd7, 32'h0, "rst_hi");
        step(r_op(6'h12, 5'd0, 5'd0, 5'd8, 5'd0));
        show(5'd8, 32'h0, "rst_lo");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
